seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 178 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scan driver with double-buffered value
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter int HEX_EN         = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  // Inactive pin levels; XOR-ing an active-high level with these gives the pin level.
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_act;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic                    r_act_valid;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_dig_sel;
  logic                    r_frame_done;

  logic [IDX_W-1:0]        w_msd;
  logic [3:0]              w_nib;
  logic                    w_nib_dp;
  logic                    w_show;
  logic [6:0]              w_seg_on;
  logic                    w_dp_on;
  logic [NUM_DIGITS-1:0]   w_dig_on;
  logic                    w_in_blank;
  logic                    w_frame_end;
  logic                    w_xfer;

  function automatic logic [6:0] f_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      4'hF: g = 7'b1000111;
    endcase
    if ((HEX_EN == 0) && (nib > 4'd9)) begin
      g = 7'b0000000;
    end
    return g;
  endfunction

  // Pick the scanned digit's nibble/dp and find the most significant nonzero digit.
  always_comb begin
    w_msd    = '0;
    w_nib    = 4'd0;
    w_nib_dp = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_act[4*k +: 4] != 4'd0) begin
        w_msd = IDX_W'(k);
      end
      if (r_idx == IDX_W'(k)) begin
        w_nib    = r_act[4*k +: 4];
        w_nib_dp = r_act_dp[k];
      end
    end
  end

  // Digit 0 is never above w_msd, so an all-zero value still shows a single "0".
  assign w_show      = r_act_valid && !(lz_blank && (r_idx > w_msd));
  assign w_seg_on    = w_show ? f_glyph(w_nib) : 7'b0000000;
  assign w_dp_on     = w_show && w_nib_dp;
  assign w_dig_on    = NUM_DIGITS'(1) << r_idx;
  assign w_in_blank  = (r_cnt < BLANK_END);
  assign w_frame_end = enable && (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);
  // While disabled nothing is on screen, so pending can be promoted without tearing.
  assign w_xfer      = r_pend_valid && (!enable || w_frame_end);

  // Slot counter and digit index; both parked at zero while scanning is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!enable) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Pending/active double buffer; a load on the boundary edge stays pending for a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend       <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_act        <= '0;
      r_act_dp     <= '0;
      r_act_valid  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_act       <= r_pend;
        r_act_dp    <= r_pend_dp;
        r_act_valid <= 1'b1;
      end
      if (load) begin
        r_pend       <= value;
        r_pend_dp    <= dp_in;
        r_pend_valid <= 1'b1;
      end else if (w_xfer) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Registered pin drivers, including the anti-ghosting blank window at slot start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_dig_sel    <= DIG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (!enable || w_in_blank) begin
        r_seg     <= SEG_OFF;
        r_dp      <= DP_OFF;
        r_dig_sel <= DIG_OFF;
      end else begin
        r_seg     <= w_seg_on ^ SEG_OFF;
        r_dp      <= w_dp_on ^ DP_OFF;
        r_dig_sel <= w_dig_on ^ DIG_OFF;
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign dig_sel    = r_dig_sel;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized model-checked bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BL = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  dig_a, dig_b;
  logic        fd_a, fd_b;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BL),
    .HEX_EN(1), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .lz_blank(lz_blank), .seg(seg_a), .dp(dp_a),
    .dig_sel(dig_a), .frame_done(fd_a)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BL),
    .HEX_EN(0), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .lz_blank(lz_blank), .seg(seg_b), .dp(dp_b),
    .dig_sel(dig_b), .frame_done(fd_b)
  );

  logic [6:0] GLY [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int          n_checks = 0;
  int          n_pass = 0;

  // reference model: elapsed enabled clocks plus the two buffers
  int          m_t;
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pdp, m_adp;
  logic        m_pv, m_av;
  logic [12:0] exp_a, exp_b;

  logic [6:0]  cap_a [4];
  logic [6:0]  cap_b [4];
  logic [3:0]  cap_dp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_t = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0; m_pv = 0; m_av = 0;
  endtask

  // expected {seg,dp,dig_sel,frame_done=0} for a given slot position
  function automatic logic [12:0] pins(input int cnt, input int slot, input logic en,
                                       input logic hex, input logic sal, input logic dal);
    logic [6:0] s;
    logic       d;
    logic [3:0] dg;
    logic [3:0] nib;
    int         msd;
    s = '0; d = 1'b0; dg = '0;
    if (en && cnt >= BL) begin
      dg  = 4'(1 << slot);
      msd = 0;
      for (int k = 0; k < N; k++) if (m_act[4*k +: 4] != 4'd0) msd = k;
      nib = m_act[4*slot +: 4];
      if (m_av && !(lz_blank && slot > msd)) begin
        s = (nib < 4'd10 || hex) ? GLY[nib] : 7'b0;
        d = m_adp[slot];
      end
    end
    if (sal) begin s = ~s; d = ~d; end
    if (dal) dg = ~dg;
    return {s, d, dg, 1'b0};
  endfunction

  task automatic step();
    int   cnt, slot;
    logic bnd, xfer;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
      exp_a = pins(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_b = pins(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    end else begin
      if (enable) begin
        cnt  = m_t % SD;
        slot = (m_t / SD) % N;
        bnd  = (m_t % (SD*N)) == (SD*N - 1);
        m_t++;
      end else begin
        cnt = 0; slot = 0; bnd = 1'b0; m_t = 0;
      end
      exp_a = pins(cnt, slot, enable, 1'b1, 1'b0, 1'b0) | {12'b0, bnd};
      exp_b = pins(cnt, slot, enable, 1'b0, 1'b1, 1'b1) | {12'b0, bnd};
      xfer = m_pv && (!enable || bnd);
      if (xfer) begin m_act = m_pend; m_adp = m_pdp; m_av = 1'b1; end
      if (load) begin m_pend = value; m_pdp = dp_in; m_pv = 1'b1; end
      else if (xfer) m_pv = 1'b0;
    end
    #1;
    check_eq("pins_a", {seg_a, dp_a, dig_a, fd_a}, exp_a);
    check_eq("pins_b", {seg_b, dp_b, dig_b, fd_b}, exp_b);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_eq("rst_async_a", {seg_a, dp_a, dig_a, fd_a}, 13'h0000);
    check_eq("rst_async_b", {seg_b, dp_b, dig_b, fd_b}, {7'h7f, 1'b1, 4'hf, 1'b0});
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic sync_fd();
    int n = 0;
    do begin step(); n++; end while (!fd_a && n < 40);
    check_eq("sync_fd", fd_a, 1);
  endtask

  // one full frame; optional loads at step indices la/lb; records per-digit glyphs
  task automatic capture(input int la, input logic [15:0] va, input int lb,
                         input logic [15:0] vb, input logic [3:0] dv);
    for (int k = 0; k < N; k++) begin cap_a[k] = 'x; cap_b[k] = 'x; cap_dp[k] = 1'bx; end
    for (int i = 0; i < SD*N; i++) begin
      if (i == la) begin load = 1'b1; value = va; dp_in = dv; end
      else if (i == lb) begin load = 1'b1; value = vb; dp_in = dv; end
      else load = 1'b0;
      step();
      for (int k = 0; k < N; k++) begin
        if (dig_a[k]) begin cap_a[k] = seg_a; cap_dp[k] = dp_a; end
        if (!dig_b[k]) cap_b[k] = seg_b;
      end
    end
    load = 1'b0;
  endtask

  function automatic logic [27:0] pack_a();
    return {cap_a[3], cap_a[2], cap_a[1], cap_a[0]};
  endfunction

  function automatic logic [27:0] pack_b();
    return {cap_b[3], cap_b[2], cap_b[1], cap_b[0]};
  endfunction

  initial begin
    int n;
    model_clear();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("reset_a", {seg_a, dp_a, dig_a, fd_a}, 13'h0000);
    check_eq("reset_b", {seg_b, dp_b, dig_b, fd_b}, {7'h7f, 1'b1, 4'hf, 1'b0});
    step();
    step();
    rst_n = 1'b1;
    enable = 1'b1;

    sync_fd();
    n = 0;
    do begin step(); n++; end while (!fd_a && n < 40);
    check_eq("fd_period", n, 16);

    capture(-1, 16'h0, -1, 16'h0, 4'h0);
    check_eq("blank_no_load", pack_a(), 28'h0);
    capture(5, 16'h1234, -1, 16'h0, 4'h0);
    check_eq("no_tear", pack_a(), 28'h0);
    capture(-1, 16'h0, -1, 16'h0, 4'h0);
    check_eq("show_1234", pack_a(), {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011});
    capture(2, 16'hABCD, -1, 16'h0, 4'h0);
    check_eq("hold_1234", pack_a(), {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011});
    capture(-1, 16'h0, -1, 16'h0, 4'h0);
    check_eq("hex_on_a", pack_a(), {7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101});
    check_eq("hex_off_b", pack_b(), {4{7'h7f}});

    lz_blank = 1'b1;
    capture(3, 16'h0040, -1, 16'h0, 4'b1000);
    capture(-1, 16'h0, -1, 16'h0, 4'h0);
    check_eq("lz_0040", pack_a(), {7'b0, 7'b0, 7'b0110011, 7'b1111110});
    check_eq("lz_dp_off", cap_dp, 4'b0000);
    capture(3, 16'h0000, -1, 16'h0, 4'h0);
    capture(-1, 16'h0, -1, 16'h0, 4'h0);
    check_eq("lz_0000", pack_a(), {7'b0, 7'b0, 7'b0, 7'b1111110});
    lz_blank = 1'b0;

    capture(3, 16'h1111, SD*N - 1, 16'h2222, 4'h0);
    capture(-1, 16'h0, -1, 16'h0, 4'h0);
    check_eq("bnd_load_old", pack_a(), {4{7'b0110000}});
    capture(-1, 16'h0, -1, 16'h0, 4'h0);
    check_eq("bnd_load_new", pack_a(), {4{7'b1101101}});

    enable = 1'b0;
    step();
    load = 1'b1; value = 16'h0987; dp_in = 4'h0;
    step();
    load = 1'b0;
    step();
    step();
    enable = 1'b1;
    capture(-1, 16'h0, -1, 16'h0, 4'h0);
    check_eq("en_restart", pack_a(), {7'b1111110, 7'b1111011, 7'b1111111, 7'b1110000});

    for (int i = 0; i < 7; i++) step();
    async_reset();
    sync_fd();
    capture(-1, 16'h0, -1, 16'h0, 4'h0);
    check_eq("post_rst_blank_a", pack_a(), 28'h0);
    check_eq("post_rst_blank_b", pack_b(), {4{7'h7f}});

    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 39) != 0) || (i % 400 > 200);
      load   = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < N; k++)
        value[4*k +: 4] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
      dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 599) == 0) async_reset();
      else step();
    end
    load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
